volume_ctrl_mc: RTL and testbench

Multi-channel, parametrised volume controller with press/auto-repeat stepping, per-channel masking, mute, and a click-free amplitude ramp. It sits between the debounced button front end and the tone/sample generators. Per channel it produces a symmetric amplitude window (amplitude_max / amplitude_min) that slews toward the target instead of jumping.

---
 rtl/volume_pkg.sv | 29 ++
 rtl/volume_ramp.sv | 48 ++++
 rtl/volume_ctrl_mc.sv | 131 +++++++++++++
 tb/tb_volume_ctrl_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// rtl/volume_pkg.sv - shared types and helpers for the volume controller
package volume_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    // Width needed to index n items; never below 1 so single-entry cases stay legal.
    function automatic int calc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] sat_step(
        input logic [15:0] v,
        input dir_t        d,
        input logic [15:0] max_v
    );
        logic [15:0] r;
        r = v;
        if (d == DIR_UP && v < max_v)
            r = v + 16'd1;
        else if (d == DIR_DOWN && v != 16'd0)
            r = v - 16'd1;
        return r;
    endfunction

endpackage

// File: rtl/volume_ramp.sv
// rtl/volume_ramp.sv - one channel amplitude slew toward a target without overshoot
module volume_ramp
    import volume_pkg::*;
#(
    parameter int          AMP_W     = 16,
    parameter logic [15:0] RAMP_STEP = 16'h0200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [AMP_W-1:0] target,
    output logic [AMP_W-1:0] amplitude,
    output logic             at_target
);

    localparam logic [AMP_W-1:0] RS = AMP_W'(RAMP_STEP);

    logic [AMP_W-1:0] amp_nxt;

    // Within one step of the target the channel snaps exactly onto it.
    always_comb begin
        amp_nxt = amplitude;
        if (tick) begin
            if (target > amplitude) begin
                if ((target - amplitude) <= RS)
                    amp_nxt = target;
                else
                    amp_nxt = amplitude + RS;
            end else if (target < amplitude) begin
                if ((amplitude - target) <= RS)
                    amp_nxt = target;
                else
                    amp_nxt = amplitude - RS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            amplitude <= '0;
            at_target <= 1'b1;
        end else begin
            amplitude <= amp_nxt;
            at_target <= (amp_nxt == target);
        end
    end

endmodule

// File: rtl/volume_ctrl_mc.sv
// rtl/volume_ctrl_mc.sv - multi-channel volume control with auto-repeat, mute and ramp
module volume_ctrl_mc
    import volume_pkg::*;
#(
    parameter int          CH         = 2,
    parameter int          LEVELS     = 16,
    parameter int          AMP_W      = 16,
    parameter logic [15:0] STEP       = 16'h0800,
    parameter int          HOLD_CYC   = 8,
    parameter int          REPEAT_CYC = 4,
    parameter int          RAMP_DIV   = 1,
    parameter logic [15:0] RAMP_STEP  = 16'h0200,
    parameter int          VOL_W      = calc_w(LEVELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  button_up,
    input  logic                  button_down,
    input  logic [CH-1:0]         ch_mask,
    input  logic                  mute_toggle,
    output logic [CH*VOL_W-1:0]   volume,
    output logic [CH*AMP_W-1:0]   amplitude_max,
    output logic [CH*AMP_W-1:0]   amplitude_min,
    output logic                  muted,
    output logic                  busy
);

    localparam int HC_W   = calc_w(HOLD_CYC + 1);
    localparam int RC_W   = calc_w(REPEAT_CYC);
    localparam int TICK_W = calc_w(RAMP_DIV);

    localparam logic [HC_W-1:0]   HOLD_MAX  = HC_W'(HOLD_CYC);
    localparam logic [RC_W-1:0]   REP_LAST  = RC_W'(REPEAT_CYC - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_DIV - 1);
    localparam logic [15:0]       VOL_MAX   = 16'(LEVELS - 1);

    dir_t            dir, dir_prev;
    logic            press, step;
    logic [HC_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [RC_W-1:0] rep_cnt, rep_cnt_nxt;

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    logic [VOL_W-1:0] vol     [CH];
    logic [CH-1:0]    at_target;

    always_comb begin
        dir = DIR_NONE;
        if (button_up && !button_down)
            dir = DIR_UP;
        else if (button_down && !button_up)
            dir = DIR_DOWN;
    end

    assign press = (dir != DIR_NONE) && (dir != dir_prev);

    // hold_cnt tracks k up to HOLD_CYC and then parks; rep_cnt paces the repeats after it.
    always_comb begin
        hold_cnt_nxt = hold_cnt;
        rep_cnt_nxt  = rep_cnt;
        step         = 1'b0;
        if (dir == DIR_NONE) begin
            hold_cnt_nxt = '0;
            rep_cnt_nxt  = '0;
        end else if (press) begin
            step         = 1'b1;
            hold_cnt_nxt = HC_W'(1);
            rep_cnt_nxt  = '0;
        end else if (hold_cnt < HOLD_MAX) begin
            hold_cnt_nxt = hold_cnt + HC_W'(1);
        end else begin
            step        = (rep_cnt == '0);
            rep_cnt_nxt = (rep_cnt == REP_LAST) ? '0 : rep_cnt + RC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_prev <= DIR_NONE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            muted    <= 1'b0;
            tick_cnt <= '0;
        end else begin
            dir_prev <= dir;
            hold_cnt <= hold_cnt_nxt;
            rep_cnt  <= rep_cnt_nxt;
            muted    <= muted ^ mute_toggle;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [AMP_W-1:0] target;
            logic [AMP_W-1:0] amp;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    vol[gi] <= '0;
                else if (step && ch_mask[gi])
                    vol[gi] <= VOL_W'(sat_step(16'(vol[gi]), dir, VOL_MAX));
            end

            assign target = muted ? '0 : AMP_W'(vol[gi]) * AMP_W'(STEP);

            volume_ramp #(
                .AMP_W     (AMP_W),
                .RAMP_STEP (RAMP_STEP)
            ) u_ramp (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .target    (target),
                .amplitude (amp),
                .at_target (at_target[gi])
            );

            assign volume[gi*VOL_W +: VOL_W]        = vol[gi];
            assign amplitude_max[gi*AMP_W +: AMP_W] = amp;
            assign amplitude_min[gi*AMP_W +: AMP_W] = ~amp + AMP_W'(1);
        end
    endgenerate

    assign busy = ~&at_target;

endmodule

// File: tb/tb_volume_ctrl_mc.sv
// tb/tb_volume_ctrl_mc.sv - scoreboard bench for volume_ctrl_mc
module tb_volume_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        button_up = 1'b0;
    logic        button_down = 1'b0;
    logic [1:0]  ch_mask = 2'b00;
    logic        mute_toggle = 1'b0;
    logic [7:0]  volume;
    logic [31:0] amplitude_max;
    logic [31:0] amplitude_min;
    logic        muted;
    logic        busy;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [15:0] amp;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    volume_ctrl_mc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button_up     (button_up),
        .button_down   (button_down),
        .ch_mask       (ch_mask),
        .mute_toggle   (mute_toggle),
        .volume        (volume),
        .amplitude_max (amplitude_max),
        .amplitude_min (amplitude_min),
        .muted         (muted),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] vol_of(input int i);
        return volume[i*4 +: 4];
    endfunction

    function automatic logic [15:0] amp_of(input int i);
        return amplitude_max[i*16 +: 16];
    endfunction

    function automatic logic [15:0] ampn_of(input int i);
        return amplitude_min[i*16 +: 16];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        button_up = 1'b0;
        button_down = 1'b0;
        mute_toggle = 1'b0;
        ch_mask = 2'b00;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic press_up(input int n);
        for (int i = 0; i < n; i++) begin
            button_up = 1'b1;
            cyc();
            button_up = 1'b0;
            cyc();
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        cyc();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy still %b after %0d cycles, need 0", name, busy, limit);
        end
    endtask

    task automatic drain_q(input string name, input int ch);
        exp_t e;
        while (exp_q.size() > 0) begin
            cyc();
            e = exp_q.pop_front();
            total++;
            if (amp_of(ch) !== e.amp || busy !== e.busy) begin
                bad++;
                $display("FAIL %s: amp=%h busy=%b, need amp=%h busy=%b",
                         name, amp_of(ch), busy, e.amp, e.busy);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (volume !== 8'h00 || amplitude_max !== 32'h0 || amplitude_min !== 32'h0 ||
            muted !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: vol=%h max=%h min=%h muted=%b busy=%b, need all 0",
                     volume, amplitude_max, amplitude_min, muted, busy);
        end
    endtask

    task automatic test_single_up();
        exp_t e;
        do_reset();
        ch_mask = 2'b11;
        button_up = 1'b1;
        cyc();
        button_up = 1'b0;
        total++;
        if (volume !== 8'h11 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_up_vol: vol=%h busy=%b, need 11 busy 0", volume, busy);
        end
        for (int i = 1; i <= 4; i++) begin
            e.amp = 16'(i * 16'h0200);
            e.busy = (i != 4);
            exp_q.push_back(e);
        end
        drain_q("single_up_ramp", 0);
        total++;
        if (amp_of(1) !== 16'h0800 || ampn_of(0) !== 16'hF800 || ampn_of(1) !== 16'hF800) begin
            bad++;
            $display("FAIL single_up_end: amp1=%h min0=%h min1=%h, need 0800 F800 F800",
                     amp_of(1), ampn_of(0), ampn_of(1));
        end
    endtask

    task automatic test_hold_repeat();
        int expv;
        do_reset();
        ch_mask = 2'b11;
        button_up = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            expv = 1 + (k >= 8 ? 1 : 0) + (k >= 12 ? 1 : 0) + (k >= 16 ? 1 : 0);
            total++;
            if (vol_of(0) !== 4'(expv) || vol_of(1) !== 4'(expv)) begin
                bad++;
                $display("FAIL hold_k%0d: vol=%h, need %0d on both", k, volume, expv);
            end
        end
        button_up = 1'b0;
    endtask

    task automatic test_mask_sat();
        do_reset();
        ch_mask = 2'b01;
        press_up(20);
        total++;
        if (vol_of(0) !== 4'd15 || vol_of(1) !== 4'd0) begin
            bad++;
            $display("FAIL mask_sat_vol: vol=%h, need 0F", volume);
        end
        wait_idle("mask_sat_idle", 100);
        total++;
        if (amp_of(0) !== 16'h7800 || amp_of(1) !== 16'h0000) begin
            bad++;
            $display("FAIL mask_sat_amp: amp0=%h amp1=%h, need 7800 0000", amp_of(0), amp_of(1));
        end
        ch_mask = 2'b11;
        button_down = 1'b1;
        cyc();
        button_down = 1'b0;
        total++;
        if (vol_of(0) !== 4'd14 || vol_of(1) !== 4'd0) begin
            bad++;
            $display("FAIL down_floor: vol=%h, need 0E", volume);
        end
    endtask

    task automatic test_both_buttons();
        do_reset();
        ch_mask = 2'b11;
        button_up = 1'b1;
        button_down = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (volume !== 8'h00) begin
                bad++;
                $display("FAIL both_held_%0d: vol=%h, need 00", i, volume);
            end
        end
        button_down = 1'b0;
        cyc();
        total++;
        if (volume !== 8'h11) begin
            bad++;
            $display("FAIL both_release: vol=%h, need 11", volume);
        end
        repeat (3) cyc();
        button_up = 1'b0;
        total++;
        if (volume !== 8'h11) begin
            bad++;
            $display("FAIL both_no_repeat: vol=%h, need 11", volume);
        end
    endtask

    task automatic test_mute_ramp();
        exp_t e;
        do_reset();
        ch_mask = 2'b11;
        press_up(15);
        wait_idle("mute_pre_idle", 200);
        mute_toggle = 1'b1;
        cyc();
        mute_toggle = 1'b0;
        total++;
        if (muted !== 1'b1 || amp_of(0) !== 16'h7800) begin
            bad++;
            $display("FAIL mute_on: muted=%b amp0=%h, need 1 7800", muted, amp_of(0));
        end
        for (int i = 1; i <= 60; i++) begin
            e.amp = 16'(32'h7800 - i * 32'h0200);
            e.busy = (i != 60);
            exp_q.push_back(e);
        end
        drain_q("mute_down", 0);
        total++;
        if (volume !== 8'hFF || amp_of(1) !== 16'h0000) begin
            bad++;
            $display("FAIL mute_hold_vol: vol=%h amp1=%h, need FF 0000", volume, amp_of(1));
        end
        mute_toggle = 1'b1;
        cyc();
        mute_toggle = 1'b0;
        repeat (30) cyc();
        total++;
        if (muted !== 1'b0 || amp_of(0) !== 16'h3C00) begin
            bad++;
            $display("FAIL unmute_mid: muted=%b amp0=%h, need 0 3C00", muted, amp_of(0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (volume !== 8'h00 || amplitude_max !== 32'h0 || amplitude_min !== 32'h0 ||
            muted !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: vol=%h max=%h min=%h muted=%b busy=%b, need all 0",
                     volume, amplitude_max, amplitude_min, muted, busy);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ch_mask = 2'b10;
        button_up = 1'b1;
        mute_toggle = 1'b1;
        cyc();
        button_up = 1'b0;
        mute_toggle = 1'b0;
        total++;
        if (muted !== 1'b1 || volume !== 8'h10) begin
            bad++;
            $display("FAIL mute_and_step: muted=%b vol=%h, need 1 10", muted, volume);
        end
        repeat (3) cyc();
        total++;
        if (amp_of(1) !== 16'h0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL muted_amp: amp1=%h busy=%b, need 0000 0", amp_of(1), busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_hold_repeat();
        test_mask_sat();
        test_both_buttons();
        test_mute_ramp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
